hack_memory_map: RTL and testbench

Parametrised data memory for the Hack computer. It decodes a single CPU address space into general RAM, screen memory and a read-only keyboard register. It adds a hardware clear engine that zeroes RAM and screen after reset, and a registered read port that the display controller uses to scan screen memory. It sits between the CPU data port (A/M register path) and the display and keyboard interfaces.

---
 rtl/hack_memory_map.sv | 124 ++++++++++++
 tb/tb_hack_memory_map.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hack_memory_map.sv
// Hack computer data memory: RAM, screen and keyboard decode. After reset, a clear
// engine zeroes RAM and screen. A registered video port reads screen memory.
module hack_memory_map #(
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned ADDR_W         = 15,
   parameter int unsigned RAM_DEPTH      = 16384,
   parameter int unsigned SCREEN_BASE    = 16384,
   parameter int unsigned SCREEN_DEPTH   = 8192,
   parameter int unsigned KBD_ADDR       = 24576,
   parameter int unsigned VID_AW         = 13,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] out,
   input  logic [DATA_W-1:0] kbd_in,
   input  logic              vid_req,
   input  logic [VID_AW-1:0] vid_addr,
   output logic [DATA_W-1:0] vid_data,
   output logic              vid_valid,
   output logic              busy,
   output logic              oob_err
);

   localparam int unsigned TOTAL  = RAM_DEPTH + SCREEN_DEPTH;
   localparam int unsigned CLR_W  = $clog2(TOTAL + 1);
   localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam int unsigned SCR_AW = (SCREEN_DEPTH > 1) ? $clog2(SCREEN_DEPTH) : 1;

   localparam logic [ADDR_W:0] RAM_END = (ADDR_W+1)'(RAM_DEPTH);
   localparam logic [ADDR_W:0] SCR_LO  = (ADDR_W+1)'(SCREEN_BASE);
   localparam logic [ADDR_W:0] SCR_HI  = (ADDR_W+1)'(SCREEN_BASE + SCREEN_DEPTH);
   localparam logic [ADDR_W:0] KBD_A   = (ADDR_W+1)'(KBD_ADDR);
   localparam logic [VID_AW:0] VID_LIM = (VID_AW+1)'(SCREEN_DEPTH);
   localparam logic [CLR_W-1:0] CLR_LAST    = CLR_W'(TOTAL - 1);
   localparam logic [CLR_W-1:0] CLR_RAM_END = CLR_W'(RAM_DEPTH);

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t            r_state, w_state_nxt;
   logic [CLR_W-1:0]  r_clr_ptr;
   logic [DATA_W-1:0] r_ram [RAM_DEPTH];
   logic [DATA_W-1:0] r_scr [SCREEN_DEPTH];
   logic [DATA_W-1:0] r_kbd, r_vid_data, w_vid_rd, w_out;
   logic              r_vid_valid, r_oob_err;

   logic [ADDR_W:0]   w_addr_x;
   logic              w_is_ram, w_is_scr, w_is_kbd;
   logic [SCR_AW-1:0] w_scr_off, w_clr_scr;
   logic              w_busy, w_cpu_we, w_clr_we, w_clr_is_ram;

   assign w_addr_x     = {1'b0, address};
   assign w_is_ram     = w_addr_x < RAM_END;
   assign w_is_scr     = (w_addr_x >= SCR_LO) && (w_addr_x < SCR_HI);
   assign w_is_kbd     = w_addr_x == KBD_A;
   assign w_scr_off    = SCR_AW'(address - ADDR_W'(SCREEN_BASE));
   assign w_busy       = r_state == S_CLEAR;
   assign w_cpu_we     = load && !w_busy && !reset;
   assign w_clr_we     = w_busy && !reset;
   assign w_clr_is_ram = r_clr_ptr < CLR_RAM_END;
   assign w_clr_scr    = SCR_AW'(r_clr_ptr - CLR_RAM_END);

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == S_CLEAR && r_clr_ptr == CLR_LAST) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
         r_clr_ptr <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_busy) r_clr_ptr <= r_clr_ptr + CLR_W'(1);
      end
   end

   // Clear and CPU writes never overlap because CPU writes are gated by busy.
   always_ff @(posedge clk) begin
      if (w_clr_we && w_clr_is_ram)      r_ram[r_clr_ptr[RAM_AW-1:0]] <= '0;
      else if (w_cpu_we && w_is_ram)     r_ram[address[RAM_AW-1:0]]   <= in;
   end

   always_ff @(posedge clk) begin
      if (w_clr_we && !w_clr_is_ram)     r_scr[w_clr_scr] <= '0;
      else if (w_cpu_we && w_is_scr)     r_scr[w_scr_off] <= in;
   end

   assign w_vid_rd = (!w_busy && ({1'b0, vid_addr} < VID_LIM))
                     ? r_scr[vid_addr[SCR_AW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_oob_err   <= 1'b0;
         r_kbd       <= '0;
         r_vid_data  <= '0;
         r_vid_valid <= 1'b0;
      end else begin
         r_kbd       <= kbd_in;
         r_vid_valid <= vid_req;
         if (vid_req) r_vid_data <= w_vid_rd;
         if (w_cpu_we && !w_is_ram && !w_is_scr) r_oob_err <= 1'b1;
      end
   end

   always_comb begin
      w_out = '0;
      if (!w_busy) begin
         if (w_is_ram)      w_out = r_ram[address[RAM_AW-1:0]];
         else if (w_is_scr) w_out = r_scr[w_scr_off];
         else if (w_is_kbd) w_out = r_kbd;
      end
   end

   assign out       = w_out;
   assign vid_data  = r_vid_data;
   assign vid_valid = r_vid_valid;
   assign busy      = w_busy;
   assign oob_err   = r_oob_err;

endmodule

// File: tb/tb_hack_memory_map.sv
// Testbench for hack_memory_map: CPU vector table, video scoreboard, and the
// clear-engine timing sequences.
module tb_hack_memory_map;

   logic        clk, reset, load, vid_req;
   logic [15:0] in, out, kbd_in, vid_data;
   logic [14:0] address;
   logic [12:0] vid_addr;
   logic        vid_valid, busy, oob_err;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [15:0] sb[$];

   hack_memory_map #(.DATA_W(16), .ADDR_W(15), .RAM_DEPTH(16384), .SCREEN_BASE(16384),
                     .SCREEN_DEPTH(8192), .KBD_ADDR(24576), .VID_AW(13),
                     .CLEAR_ON_RESET(1)) dut (
      .clk(clk), .reset(reset), .in(in), .load(load), .address(address), .out(out),
      .kbd_in(kbd_in), .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
      .vid_valid(vid_valid), .busy(busy), .oob_err(oob_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Counts edges after reset release until busy drops; optionally pokes CPU writes.
   task automatic wait_clear(input bit poke, output int unsigned n);
      n = 0;
      do begin
         load = 1'b0;
         if (poke && n >= 100 && n < 200) begin
            load = 1'b1; address = 15'h0007; in = 16'h7777;
         end else if (poke && n >= 200 && n < 300) begin
            load = 1'b1; address = 15'h6000; in = 16'h1111;
         end
         tick;
         n++;
      end while (busy === 1'b1 && n < 30000);
      load = 1'b0;
   endtask

   always @(posedge clk) begin
      #1;
      if (vid_valid === 1'b1) begin
         if (sb.size() == 0) chk("vid_unexpected_valid", 32'(vid_valid), 32'h0);
         else                chk("vid_data", 32'(vid_data), 32'(sb.pop_front()));
      end
   end

   typedef struct {
      logic        ld;
      logic [14:0] a;
      logic [15:0] d;
      logic [15:0] eo;
      logic        eoob;
   } vec_t;

   vec_t vt[14];

   initial begin
      int unsigned n;
      vt[0]  = '{1'b0, 15'h0000, 16'h0000, 16'h0000, 1'b0};
      vt[1]  = '{1'b0, 15'h3FFF, 16'h0000, 16'h0000, 1'b0};
      vt[2]  = '{1'b0, 15'h4000, 16'h0000, 16'h0000, 1'b0};
      vt[3]  = '{1'b0, 15'h5FFF, 16'h0000, 16'h0000, 1'b0};
      vt[4]  = '{1'b1, 15'h0005, 16'hBEEF, 16'hBEEF, 1'b0};
      vt[5]  = '{1'b1, 15'h4000, 16'h1234, 16'h1234, 1'b0};
      vt[6]  = '{1'b1, 15'h3FFF, 16'hA5A5, 16'hA5A5, 1'b0};
      vt[7]  = '{1'b1, 15'h5FFF, 16'h5A5A, 16'h5A5A, 1'b0};
      vt[8]  = '{1'b0, 15'h4005, 16'h0000, 16'h0000, 1'b0};
      vt[9]  = '{1'b0, 15'h6001, 16'h0000, 16'h0000, 1'b0};
      vt[10] = '{1'b1, 15'h6000, 16'hDEAD, 16'h0000, 1'b1};
      vt[11] = '{1'b1, 15'h7000, 16'hCAFE, 16'h0000, 1'b1};
      vt[12] = '{1'b0, 15'h0005, 16'h0000, 16'hBEEF, 1'b1};
      vt[13] = '{1'b0, 15'h4000, 16'h0000, 16'h1234, 1'b1};

      reset = 1'b1; load = 1'b0; in = '0; address = '0; kbd_in = '0;
      vid_req = 1'b0; vid_addr = '0;
      tick; tick;
      chk("rst_busy", 32'(busy), 32'h1);
      chk("rst_oob", 32'(oob_err), 32'h0);
      chk("rst_vid_valid", 32'(vid_valid), 32'h0);
      chk("rst_vid_data", 32'(vid_data), 32'h0);
      chk("rst_out", 32'(out), 32'h0);

      reset = 1'b0;
      wait_clear(1'b0, n);
      chk("clear_cycles", n, 32'd24576);

      foreach (vt[i]) begin
         address = vt[i].a; in = vt[i].d; load = vt[i].ld;
         tick;
         load = 1'b0;
         #1;
         chk($sformatf("vec%0d_out", i), 32'(out), 32'(vt[i].eo));
         chk($sformatf("vec%0d_oob", i), 32'(oob_err), 32'(vt[i].eoob));
      end

      // Back-to-back video reads of the first and last screen words.
      vid_req = 1'b1; vid_addr = 13'h0000; sb.push_back(16'h1234);
      tick;
      vid_addr = 13'h1FFF; sb.push_back(16'h5A5A);
      tick;
      vid_req = 1'b0;
      tick; tick;
      chk("vid_b2b_drained", sb.size(), 32'h0);
      chk("vid_pulse_low", 32'(vid_valid), 32'h0);

      // Same-cycle CPU write and video read return the old word.
      address = 15'h4003; in = 16'h00FF; load = 1'b1;
      tick;
      in = 16'hFF00; vid_req = 1'b1; vid_addr = 13'h0003; sb.push_back(16'h00FF);
      tick;
      load = 1'b0; sb.push_back(16'hFF00);
      tick;
      vid_req = 1'b0;
      tick; tick;
      chk("rbw_drained", sb.size(), 32'h0);

      address = 15'h6000; kbd_in = 16'h0041;
      #1;
      chk("kbd_before_edge", 32'(out), 32'h0);
      tick;
      chk("kbd_capture", 32'(out), 32'h0041);
      kbd_in = 16'h0000;
      tick;
      chk("kbd_clear", 32'(out), 32'h0);
      chk("oob_sticky", 32'(oob_err), 32'h1);

      reset = 1'b1;
      tick;
      chk("rst2_oob", 32'(oob_err), 32'h0);
      chk("rst2_vid_data", 32'(vid_data), 32'h0);
      chk("rst2_busy", 32'(busy), 32'h1);
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         vid_req = (i == 50);
         if (i == 50) begin vid_addr = 13'h0001; sb.push_back(16'h0000); end
         address = 15'h5FFF;
         tick;
         if (i == 60) chk("out_gated_busy", 32'(out), 32'h0);
      end
      vid_req = 1'b0;
      chk("busy_vid_drained", sb.size(), 32'h0);

      reset = 1'b1;
      tick;
      reset = 1'b0;
      wait_clear(1'b1, n);
      chk("reclear_cycles", n, 32'd24576);
      address = 15'h0007;
      #1;
      chk("busy_write_dropped", 32'(out), 32'h0);
      chk("busy_write_no_oob", 32'(oob_err), 32'h0);
      address = 15'h5FFF;
      #1;
      chk("reclear_screen_top", 32'(out), 32'h0);

      tick;
      chk("sb_empty", sb.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
